bcache_update_arb: RTL and testbench

//  Serialises branch-resolution events from two requesters (e.g. two issue

---
 rtl/bcache_pkg.sv | 25 ++
 rtl/bcache_upd_fifo.sv | 56 +++++
 rtl/bcache_update_arb.sv | 151 +++++++++++++++
 tb/tb_bcache_update_arb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcache_pkg.sv
// Shared types for the branch-cache update arbiter: update record, FSM states
// and a saturating counter helper.
package bcache_pkg;

  localparam int unsigned BCACHE_ADDR_W = 12;

  typedef struct packed {
    logic                     taken;
    logic [BCACHE_ADDR_W-1:0] pc;
    logic [BCACHE_ADDR_W-1:0] target;
  } Bcache_update;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HOLD,
    ST_FLUSH
  } Arb_state;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/bcache_upd_fifo.sv
// Small circular FIFO holding pending branch-cache updates; clear wins over push/pop.
module bcache_upd_fifo #(
  parameter int unsigned depth = 4,
  parameter int unsigned width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [width-1:0]       wdata,
  output logic [width-1:0]       rdata,
  output logic [$clog2(depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == ($clog2(depth)+1)'(depth));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values; blocking = here would create order-dependent behaviour.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bcache_update_arb.sv
// Round-robin arbiter serialising two branch-resolution streams into the
// branch target cache update port. Optional counters: BCACHE_ARB_STATS_EN.
module bcache_update_arb
  import bcache_pkg::*;
#(
  parameter int unsigned addr_width = BCACHE_ADDR_W,
  parameter int unsigned depth      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_taken,
  input  logic [2*addr_width-1:0] req_pc,
  input  logic [2*addr_width-1:0] req_target,
  input  logic                    upd_enable,
  input  logic                    upd_flush,
  output logic                    taken,
  output logic                    not_taken,
  output logic [addr_width-1:0]   pc,
  output logic [addr_width-1:0]   jump_vec,
  output logic                    busy
`ifdef BCACHE_ARB_STATS_EN
  ,
  output logic [31:0]             stat_updates,
  output logic [31:0]             stat_stalls,
  output logic [31:0]             stat_flushed
`endif
);

  localparam int unsigned CW = $clog2(depth) + 1;

  Arb_state     state, state_nxt;
  logic         pop_en, acc_en;
  logic         rr;
  logic [1:0]   grant;
  logic         both_valid, accept, pop, clear;
  Bcache_update push_data, head;
  logic [CW-1:0] count;
  logic         full, empty;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // FSM: next state; flush outranks enable
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (upd_flush) state_nxt = ST_FLUSH;
                else if (!upd_enable) state_nxt = ST_HOLD;
      ST_HOLD:  if (upd_flush) state_nxt = ST_FLUSH;
                else if (upd_enable) state_nxt = ST_RUN;
      ST_FLUSH: state_nxt = upd_enable ? ST_RUN : ST_HOLD;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pop_en = (state == ST_RUN);
    acc_en = (state != ST_FLUSH);
  end

  always_comb begin
    both_valid = &req_valid;
    grant      = both_valid ? (rr ? 2'b10 : 2'b01) : req_valid;
    req_ready  = (!reset && !full && acc_en) ? grant : 2'b00;
  end

  assign accept = |req_ready;
  assign pop    = pop_en && !empty;
  // Queue is discarded on the edge that enters FLUSH.
  assign clear  = (state_nxt == ST_FLUSH) && (state != ST_FLUSH);

  always_comb begin
    push_data.taken  = req_ready[1] ? req_taken[1] : req_taken[0];
    push_data.pc     = req_ready[1] ? req_pc[2*addr_width-1:addr_width]
                                    : req_pc[addr_width-1:0];
    push_data.target = req_ready[1] ? req_target[2*addr_width-1:addr_width]
                                    : req_target[addr_width-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset)                   rr <= 1'b0;
    else if (accept && both_valid) rr <= ~rr;
  end

  bcache_upd_fifo #(
    .depth (depth),
    .width ($bits(Bcache_update))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .clear (clear),
    .wdata (push_data),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Pulses last exactly one cycle; pc/jump_vec hold their last issued value.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken     <= 1'b0;
      not_taken <= 1'b0;
      pc        <= '0;
      jump_vec  <= '0;
    end else begin
      taken     <= pop && head.taken;
      not_taken <= pop && !head.taken;
      if (pop) begin
        pc       <= head.pc;
        jump_vec <= head.target;
      end
    end
  end

  assign busy = !empty || taken || not_taken;

`ifdef BCACHE_ARB_STATS_EN
  logic [31:0] flushed_n;
  assign flushed_n = 32'(count) + 32'(accept) - 32'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_updates <= '0;
      stat_stalls  <= '0;
      stat_flushed <= '0;
    end else begin
      if (taken || not_taken)          stat_updates <= sat_add(stat_updates, 32'd1);
      if (|(req_valid & ~req_ready))   stat_stalls  <= sat_add(stat_stalls, 32'd1);
      if (clear)                       stat_flushed <= sat_add(stat_flushed, flushed_n);
    end
  end
`endif

`ifndef SYNTHESIS
  a_pulse_excl: assert property (@(posedge clk) disable iff (reset) !(taken && not_taken));
  a_count_max:  assert property (@(posedge clk) disable iff (reset) count <= CW'(depth));
  a_ready_one:  assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
`endif

endmodule

// File: tb/tb_bcache_update_arb.sv
// Scoreboard bench for bcache_update_arb: directed stimulus queues expected
// updates, a negedge monitor checks every cache pulse against the queue.
module tb_bcache_update_arb;

  localparam int AW = 12;

  typedef struct {
    logic          taken;
    logic [AW-1:0] pc;
    logic [AW-1:0] tgt;
    int            exp_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid, req_ready, req_taken;
  logic [2*AW-1:0] req_pc, req_target;
  logic          upd_enable, upd_flush;
  logic          taken, not_taken, busy;
  logic [AW-1:0] pc, jump_vec;
`ifdef BCACHE_ARB_STATS_EN
  logic [31:0]   stat_updates, stat_stalls, stat_flushed;
`endif

  exp_t sb[$];
  int   pulse_log[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcache_update_arb #(.addr_width(AW), .depth(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_taken  (req_taken),
    .req_pc     (req_pc),
    .req_target (req_target),
    .upd_enable (upd_enable),
    .upd_flush  (upd_flush),
    .taken      (taken),
    .not_taken  (not_taken),
    .pc         (pc),
    .jump_vec   (jump_vec),
    .busy       (busy)
`ifdef BCACHE_ARB_STATS_EN
    ,
    .stat_updates (stat_updates),
    .stat_stalls  (stat_stalls),
    .stat_flushed (stat_flushed)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every cache pulse must match the oldest expected update.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (taken || not_taken)) begin
      pulse_log.push_back(cyc);
      check("pulse_exclusive", 32'(taken && not_taken), 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: pc 0x%0h at cycle %0d, none expected", pc, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_taken",     32'(taken),     32'(e.taken));
        check("pulse_not_taken", 32'(not_taken), 32'(!e.taken));
        check("pulse_pc",        32'(pc),        32'(e.pc));
        check("pulse_jump_vec",  32'(jump_vec),  32'(e.tgt));
        if (e.exp_cyc >= 0) check("pulse_cycle", 32'(cyc), 32'(e.exp_cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic t, input logic [AW-1:0] p, input logic [AW-1:0] g);
    req_valid[r]           = 1'b1;
    req_taken[r]           = t;
    req_pc[r*AW +: AW]     = p;
    req_target[r*AW +: AW] = g;
  endtask

  // Hold one request until accepted; lat >= 0 fixes the expected issue cycle.
  task automatic push_one(input int r, input logic t, input logic [AW-1:0] p,
                          input logic [AW-1:0] g, input int lat);
    bit done = 1'b0;
    set_req(r, t, p, g);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        sb.push_back('{t, p, g, (lat >= 0) ? cyc + lat : -1});
        done = 1'b1;
      end
      tick();
    end
    req_valid[r] = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: requester %0d never ready, expected accept", r);
    end
  endtask

  task automatic wait_drain();
    int i = 0;
    while ((sb.size() != 0 || busy) && i < 60) begin
      @(negedge clk);
      i++;
    end
    check("drain", 32'(sb.size() == 0 && !busy), 32'd1);
    tick();
  endtask

  initial begin
    logic [AW-1:0] a_pc[2], a_tg[2], b_pc[2], b_tg[2];
    logic          a_t[2], b_t[2];
    logic [1:0]    exp_rdy[4];
    int            n0, n1, e_cyc, base;

    a_pc = '{12'h100, 12'h104}; a_tg = '{12'h110, 12'h114}; a_t = '{1'b1, 1'b0};
    b_pc = '{12'h200, 12'h204}; b_tg = '{12'h210, 12'h214}; b_t = '{1'b1, 1'b0};
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};

    reset = 1'b1; upd_enable = 1'b1; upd_flush = 1'b0;
    req_valid = 2'b01; req_taken = '0; req_pc = '0; req_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready",     32'(req_ready), 32'd0);
    check("reset_taken",     32'(taken),     32'd0);
    check("reset_not_taken", 32'(not_taken), 32'd0);
    check("reset_pc",        32'(pc),        32'd0);
    check("reset_jump_vec",  32'(jump_vec),  32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    tick();
    reset = 1'b0; req_valid = 2'b00;

    // Single taken request: pulse two cycles after accept, then values held.
    push_one(0, 1'b1, 12'h010, 12'h200, 2);
    wait_drain();
    @(negedge clk);
    check("hold_pc",        32'(pc),        32'h010);
    check("hold_jump_vec",  32'(jump_vec),  32'h200);
    check("idle_taken",     32'(taken),     32'd0);
    tick();

    // Both requesters contending: grants alternate 0,1,0,1.
    n0 = 0; n1 = 0;
    for (int k = 0; k < 4; k++) begin
      req_valid = 2'b00;
      if (n0 < 2) set_req(0, a_t[n0], a_pc[n0], a_tg[n0]);
      if (n1 < 2) set_req(1, b_t[n1], b_pc[n1], b_tg[n1]);
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(exp_rdy[k]));
      if (req_ready[0] && n0 < 2) begin sb.push_back('{a_t[n0], a_pc[n0], a_tg[n0], -1}); n0++; end
      if (req_ready[1] && n1 < 2) begin sb.push_back('{b_t[n1], b_pc[n1], b_tg[n1], -1}); n1++; end
      tick();
    end
    req_valid = 2'b00;
    wait_drain();
`ifdef BCACHE_ARB_STATS_EN
    check("stat_stalls_rr", stat_stalls, 32'd3);
`endif

    // Hold with a full FIFO, then release: five pulses back to back.
    upd_enable = 1'b0;
    for (int i = 0; i < 4; i++)
      push_one(0, (i % 2) == 0, 12'(12'h300 + 4*i), 12'(12'h380 + 4*i), -1);
    set_req(0, 1'b1, 12'h3F0, 12'h3F8);
    @(negedge clk);
    check("full_block", 32'(req_ready), 32'd0);
    tick();
    upd_enable = 1'b1;
    e_cyc = cyc;
    @(negedge clk);
    check("hold_full_block", 32'(req_ready), 32'd0);
    tick();
    @(negedge clk);
    check("no_pop_bypass", 32'(req_ready), 32'd0);
    tick();
    @(negedge clk);
    check("push_pop_accept", 32'(req_ready), 32'b01);
    if (req_ready[0]) sb.push_back('{1'b1, 12'h3F0, 12'h3F8, e_cyc + 6});
    tick();
    req_valid = 2'b00;
    wait_drain();
    base = pulse_log.size() - 5;
    for (int i = 0; i < 5; i++)
      check("b2b_cycle", 32'((base + i >= 0) ? pulse_log[base + i] : -1), 32'(e_cyc + 2 + i));

    // Flush three held entries; FLUSH cycle refuses requests.
    upd_enable = 1'b0;
    for (int i = 0; i < 3; i++)
      push_one(1, 1'b1, 12'(12'h500 + 4*i), 12'(12'h580 + 4*i), -1);
    upd_flush = 1'b1;
    @(negedge clk);
    tick();
    upd_flush = 1'b0;
    sb.delete();
    set_req(0, 1'b0, 12'h600, 12'h680);
    @(negedge clk);
    check("flush_ready", 32'(req_ready), 32'd0);
    check("flush_busy",  32'(busy),      32'd0);
`ifdef BCACHE_ARB_STATS_EN
    check("stat_flushed", stat_flushed, 32'd3);
`endif
    tick();
    @(negedge clk);
    check("post_flush_accept", 32'(req_ready), 32'b01);
    if (req_ready[0]) sb.push_back('{1'b0, 12'h600, 12'h680, -1});
    tick();
    req_valid = 2'b00;
    upd_enable = 1'b1;
    wait_drain();
`ifdef BCACHE_ARB_STATS_EN
    check("stat_updates", stat_updates, 32'd11);
    check("stat_stalls",  stat_stalls,  32'd7);
`endif

    // Reset with two queued (rr is 1 here): everything cleared, rr back to 0.
    upd_enable = 1'b0;
    push_one(0, 1'b1, 12'h700, 12'h780, -1);
    push_one(1, 1'b0, 12'h704, 12'h784, -1);
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst2_taken",     32'(taken),     32'd0);
    check("rst2_not_taken", 32'(not_taken), 32'd0);
    check("rst2_pc",        32'(pc),        32'd0);
    check("rst2_jump_vec",  32'(jump_vec),  32'd0);
    check("rst2_busy",      32'(busy),      32'd0);
`ifdef BCACHE_ARB_STATS_EN
    check("rst2_stat_updates", stat_updates, 32'd0);
    check("rst2_stat_flushed", stat_flushed, 32'd0);
`endif
    tick();
    set_req(0, 1'b1, 12'h800, 12'h880);
    set_req(1, 1'b1, 12'h900, 12'h980);
    @(negedge clk);
    check("rr_after_reset", 32'(req_ready), 32'b01);
    if (req_ready[0]) sb.push_back('{1'b1, 12'h800, 12'h880, -1});
    if (req_ready[1]) sb.push_back('{1'b1, 12'h900, 12'h980, -1});
    tick();
    req_valid = 2'b00;
    upd_enable = 1'b1;
    wait_drain();
`ifdef BCACHE_ARB_STATS_EN
    check("rst2_stat_stalls", stat_stalls, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
